// File: rtl/coproc_vec_io_if.sv
// Host/coprocessor bundle for the vector I/O stage:
// word streams in and out, register-file write port, result lanes.
interface coproc_vec_io_if #(
   parameter int n     = 32,
   parameter int N     = 32 * n,
   parameter int LANES = 3
);
   logic [31:0]  in_data;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   in_lane;
   logic [4:0]   in_addr;
   logic [N-1:0] wr_vec;
   logic [1:0]   wr_lane;
   logic [4:0]   wr_addr;
   logic         wr_en;
   logic         rd_start;
   logic [1:0]   rd_lane;
   logic         read_result;
   logic [N-1:0] rd_vec [LANES];
   logic [31:0]  out_data;
   logic         out_valid;
   logic         out_ready;
   logic         busy;

   modport slave (
      input  in_data, in_valid, in_lane, in_addr,
      input  rd_start, rd_lane, rd_vec, out_ready,
      output in_ready, wr_vec, wr_lane, wr_addr, wr_en,
      output read_result, out_data, out_valid, busy
   );

   modport master (
      output in_data, in_valid, in_lane, in_addr,
      output rd_start, rd_lane, rd_vec, out_ready,
      input  in_ready, wr_vec, wr_lane, wr_addr, wr_en,
      input  read_result, out_data, out_valid, busy
   );
endinterface

// File: rtl/coproc_vec_io.sv
// Vector I/O stage: packs n host words into one register-file write,
// and streams a captured result lane back out as n words.
module coproc_vec_io #(
   parameter int n     = 32,
   parameter int N     = 32 * n,
   parameter int LANES = 3
) (
   input logic           clk,
   input logic           rst,
   coproc_vec_io_if.slave io
);
   localparam int CW = $clog2(n) + 1;
   localparam logic [CW-1:0] LAST = CW'(n - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, WRITE, RDREQ, RDWAIT, UNLOAD
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   shift;
   logic [N-1:0]   shift_in;
   logic [N-1:0]   sel_vec;
   logic [N-1:0]   wr_vec_q;
   logic [1:0]     ld_lane;
   logic [4:0]     ld_addr;
   logic [1:0]     wr_lane_q;
   logic [4:0]     wr_addr_q;
   logic [1:0]     rd_lane_q;
   logic           in_hs;
   logic           out_hs;
   logic           last_in;
   logic           last_out;

   assign in_hs    = io.in_valid & io.in_ready;
   assign out_hs   = io.out_valid & io.out_ready;
   assign last_in  = (state == IDLE && n == 1) ||
                     (state == LOAD && cnt == LAST);
   assign last_out = cnt == LAST;
   // Shifting in at the LSB leaves coefficient 0 in the MSB slice.
   assign shift_in = (shift << 32) | N'(io.in_data);

   // Lane 3 (and any lane past LANES-1) reads back as zeros.
   always_comb begin
      sel_vec = '0;
      for (int i = 0; i < LANES; i++) begin
         if (rd_lane_q == 2'(i)) sel_vec = io.rd_vec[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (in_hs)
               state_nxt = last_in ? WRITE : LOAD;
            else if (io.rd_start)
               state_nxt = RDREQ;
         end
         LOAD:   if (in_hs && last_in) state_nxt = WRITE;
         WRITE:  state_nxt = IDLE;
         RDREQ:  state_nxt = RDWAIT;
         RDWAIT: state_nxt = UNLOAD;
         UNLOAD: if (out_hs && last_out) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         shift     <= '0;
         wr_vec_q  <= '0;
         ld_lane   <= '0;
         ld_addr   <= '0;
         wr_lane_q <= '0;
         wr_addr_q <= '0;
         rd_lane_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_hs) begin
                  shift   <= shift_in;
                  cnt     <= CW'(1);
                  ld_lane <= io.in_lane;
                  ld_addr <= io.in_addr;
                  if (last_in) begin
                     wr_vec_q  <= shift_in;
                     wr_lane_q <= io.in_lane;
                     wr_addr_q <= io.in_addr;
                  end
               end else if (io.rd_start) begin
                  rd_lane_q <= io.rd_lane;
               end
            end
            LOAD: begin
               if (in_hs) begin
                  shift <= shift_in;
                  cnt   <= cnt + 1'b1;
                  if (last_in) begin
                     wr_vec_q  <= shift_in;
                     wr_lane_q <= ld_lane;
                     wr_addr_q <= ld_addr;
                  end
               end
            end
            RDWAIT: begin
               shift <= sel_vec;
               cnt   <= '0;
            end
            UNLOAD: begin
               if (out_hs) begin
                  shift <= shift << 32;
                  cnt   <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign io.in_ready    = ~rst & (state == IDLE || state == LOAD);
   assign io.wr_en       = state == WRITE;
   assign io.read_result = state == RDREQ;
   assign io.out_valid   = state == UNLOAD;
   assign io.busy        = state != IDLE;
   assign io.out_data    = shift[N-1 -: 32];
   assign io.wr_vec      = wr_vec_q;
   assign io.wr_lane     = wr_lane_q;
   assign io.wr_addr     = wr_addr_q;
endmodule

// File: tb/tb_coproc_vec_io.sv
// Bench for coproc_vec_io with n=4: load table, hand sequences,
// and randomized loads/readbacks against a slice-level model.
module tb_coproc_vec_io;
   localparam int NW = 4;
   localparam int NB = 32 * NW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   coproc_vec_io_if #(.n(NW)) io ();

   coproc_vec_io #(.n(NW)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   typedef struct {
      logic [0:3][31:0] w;
      logic [1:0]       lane;
      logic [4:0]       addr;
      int               gap_at;
      int               gap_len;
      logic [NB-1:0]    exp_vec;
      int               exp_cyc;
   } ld_vec_t;

   ld_vec_t tbl [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [NB-1:0] act,
                        input logic [NB-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [0:3][31:0] w,
                          input logic [1:0] lane,
                          input logic [4:0] addr,
                          input int gap_at, input int gap_len,
                          input logic [NB-1:0] exp_vec,
                          input int exp_cyc, input string tag);
      int   k = 0;
      int   g = 0;
      int   cyc = 0;
      int   wcyc = -1;
      logic hs;
      while (cyc < 40 && wcyc < 0) begin
         if (k < 4 && k == gap_at && g < gap_len) begin
            io.in_valid = 1'b0;
            g++;
         end else if (k < 4) begin
            io.in_valid = 1'b1;
            io.in_data  = w[k];
            io.in_lane  = (k == 0) ? lane : 2'($urandom);
            io.in_addr  = (k == 0) ? addr : 5'($urandom);
         end else begin
            io.in_valid = 1'b0;
         end
         hs = io.in_valid & io.in_ready;
         tick();
         cyc++;
         if (hs) k++;
         if (io.wr_en) wcyc = cyc;
      end
      io.in_valid = 1'b0;
      check({tag, " latency"}, NB'(wcyc), NB'(exp_cyc));
      check({tag, " vec"}, io.wr_vec, exp_vec);
      check({tag, " lane/addr"}, NB'({io.wr_lane, io.wr_addr}),
            NB'({lane, addr}));
      check({tag, " ready in write"}, NB'(io.in_ready), NB'(0));
      tick();
      check({tag, " strobe width"}, NB'(io.wr_en), NB'(0));
      check({tag, " vec hold"}, io.wr_vec, exp_vec);
   endtask

   task automatic do_read(input logic [1:0] lane, input int mode,
                          input string tag);
      logic [31:0] exp_q[$];
      logic [NB-1:0] v128;
      int   cyc = 0;
      int   got = 0;
      int   pulses = 0;
      int   rr_cyc = -1;
      int   first = -1;
      int   rdy_bad = 0;
      logic rdy, hs, v, prev_v, prev_hs;
      logic [31:0] d, prev_d;
      prev_v = 1'b0;
      prev_hs = 1'b0;
      prev_d = '0;
      for (int k = 0; k < 4; k++) begin
         v128 = (lane < 3) ? io.rd_vec[lane] : '0;
         exp_q.push_back(v128[NB-1-32*k -: 32]);
      end
      io.rd_lane  = lane;
      io.rd_start = 1'b1;
      while (got < 4 && cyc < 60) begin
         if (mode == 0)      rdy = 1'b1;
         else if (mode == 1) rdy = cyc[0];
         else                rdy = 1'($urandom);
         io.out_ready = rdy;
         v  = io.out_valid;
         d  = io.out_data;
         hs = v & rdy;
         if (v && first < 0) first = cyc;
         if (io.read_result) begin
            pulses++;
            if (rr_cyc < 0) rr_cyc = cyc;
         end
         if (io.busy && io.in_ready) rdy_bad++;
         if (prev_v && !prev_hs && v)
            check({tag, " hold"}, NB'(d), NB'(prev_d));
         if (hs) begin
            check({tag, " word"}, NB'(d), NB'(exp_q.pop_front()));
            got++;
         end
         prev_v  = v;
         prev_hs = hs;
         prev_d  = d;
         tick();
         cyc++;
         if (cyc == 1) io.rd_start = 1'b0;
      end
      io.out_ready = 1'b0;
      check({tag, " words"}, NB'(got), NB'(4));
      check({tag, " rr cycle"}, NB'(rr_cyc), NB'(1));
      check({tag, " rr pulses"}, NB'(pulses), NB'(1));
      check({tag, " first valid"}, NB'(first), NB'(3));
      check({tag, " in_ready low"}, NB'(rdy_bad), NB'(0));
      check({tag, " idle after"}, NB'({io.out_valid, io.busy}), NB'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:3][31:0] w;
      logic [NB-1:0]    ev;
      int               pulses;
      int               gl;

      io.in_data   = '0;
      io.in_valid  = 1'b0;
      io.in_lane   = '0;
      io.in_addr   = '0;
      io.rd_start  = 1'b0;
      io.rd_lane   = '0;
      io.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) io.rd_vec[i] = '0;

      tbl[0].w = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      tbl[0].lane = 2'd1; tbl[0].addr = 5'd5;
      tbl[0].gap_at = 4; tbl[0].gap_len = 0;
      tbl[0].exp_vec = 128'h11111111_22222222_33333333_44444444;
      tbl[0].exp_cyc = 4;
      tbl[1] = tbl[0];
      tbl[1].gap_at = 2; tbl[1].gap_len = 4; tbl[1].exp_cyc = 8;
      tbl[2].w = {32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};
      tbl[2].lane = 2'd3; tbl[2].addr = 5'd31;
      tbl[2].gap_at = 4; tbl[2].gap_len = 0;
      tbl[2].exp_vec = 128'hDEADBEEF_00000000_FFFFFFFF_12345678;
      tbl[2].exp_cyc = 4;
      tbl[3].w = {32'h1, 32'h2, 32'h3, 32'h4};
      tbl[3].lane = 2'd0; tbl[3].addr = 5'd0;
      tbl[3].gap_at = 0; tbl[3].gap_len = 2;
      tbl[3].exp_vec = 128'h00000001_00000002_00000003_00000004;
      tbl[3].exp_cyc = 6;

      // Reset: everything low while rst is held.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst ctrl", NB'({io.in_ready, io.wr_en, io.read_result,
                                io.out_valid, io.busy}), NB'(0));
         check("rst vec", io.wr_vec, NB'(0));
         check("rst regs", NB'({io.wr_lane, io.wr_addr, io.out_data}),
               NB'(0));
      end
      rst = 1'b0;
      #1;
      check("post-rst ready", NB'({io.in_ready, io.busy}), NB'(2'b10));

      for (int i = 0; i < 4; i++)
         do_load(tbl[i].w, tbl[i].lane, tbl[i].addr, tbl[i].gap_at,
                 tbl[i].gap_len, tbl[i].exp_vec, tbl[i].exp_cyc,
                 $sformatf("load%0d", i));

      // Aborted vector: reset after two words, no write may follow.
      io.in_valid = 1'b1; io.in_lane = 2'd1; io.in_addr = 5'd5;
      io.in_data = 32'h55555555;
      tick();
      io.in_data = 32'h66666666;
      tick();
      io.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (io.wr_en) pulses++;
      end
      check("abort no write", NB'(pulses), NB'(0));
      check("abort vec cleared", io.wr_vec, NB'(0));
      check("abort idle", NB'({io.busy, io.in_ready}), NB'(2'b01));

      // Readback of lane 2, free-flowing then with toggled ready.
      io.rd_vec[0] = {4{32'h01020304}};
      io.rd_vec[1] = {4{32'h0A0B0C0D}};
      io.rd_vec[2] = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
      do_read(2'd2, 0, "rd lane2");
      do_read(2'd2, 1, "rd lane2 toggle");

      // Reset in the middle of an unload drops the rest.
      io.rd_lane = 2'd2; io.rd_start = 1'b1;
      tick();
      io.rd_start = 1'b0;
      tick();
      tick();
      check("mid-unload w0", NB'({io.out_valid, io.out_data}),
            NB'({1'b1, 32'hAAAAAAAA}));
      io.out_ready = 1'b1;
      tick();
      check("mid-unload w1", NB'(io.out_data), NB'(32'hBBBBBBBB));
      rst = 1'b1;
      io.out_ready = 1'b0;
      tick();
      rst = 1'b0;
      check("mid-unload drop", NB'({io.out_valid, io.busy}), NB'(0));
      tick();
      check("mid-unload idle", NB'(io.out_valid), NB'(0));

      // Load and readback requested together: load goes first.
      io.rd_lane = 2'd3;
      io.rd_start = 1'b1;
      do_load(tbl[0].w, 2'd1, 5'd5, 4, 0, tbl[0].exp_vec, 4, "arb load");
      do_read(2'd3, 1, "arb rd lane3");

      // Randomized traffic against the slice model.
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            ev = '0;
            for (int k = 0; k < 4; k++) begin
               w[k] = $urandom;
               ev[NB-1-32*k -: 32] = w[k];
            end
            gl = $urandom_range(0, 3);
            do_load(w, 2'($urandom_range(0, 3)), 5'($urandom), 
                    $urandom_range(0, 3), gl, ev, 4 + gl, "rnd load");
         end else begin
            for (int l = 0; l < 3; l++)
               io.rd_vec[l] = {$urandom, $urandom, $urandom, $urandom};
            do_read(2'($urandom_range(0, 3)), 2, "rnd read");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
